// File: rtl/btn_step_counter.sv
// Debounced, auto-repeating up/down counter fed by three raw push-buttons (inc, dec, clr).
// Each button: 2-flop synchroniser -> debouncer -> press edge; inc/dec add a repeat FSM.
module btn_step_counter #(
  parameter int unsigned N               = 16,
  parameter int unsigned MAX             = 2**N-1,
  parameter bit          SATURATE        = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_RATE     = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_inc,
  input  logic         btn_dec,
  input  logic         btn_clr,
  output logic [N-1:0] count,
  output logic         at_max,
  output logic         at_min,
  output logic         step
);

  localparam int unsigned DcW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TmW   = $clog2(TmMax + 1);

  localparam logic [N-1:0]   MaxVal    = N'(MAX);
  localparam logic [DcW-1:0] DcLast    = DcW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmW-1:0] DelayLast = TmW'(REPEAT_DELAY - 1);
  localparam logic [TmW-1:0] RateLast  = TmW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  // Bit order for all per-button vectors: [0]=inc, [1]=dec, [2]=clr.
  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] db_q, db_d, db_prev_q;
  logic [2:0] press;
  logic [DcW-1:0] dc_q [3];
  logic [DcW-1:0] dc_d [3];

  state_e         state_q [2];
  state_e         state_d [2];
  logic [TmW-1:0] timer_q [2];
  logic [TmW-1:0] timer_d [2];
  logic [1:0]     req;

  logic [N-1:0] count_q, count_d;
  logic         step_q, at_max_q, at_min_q;

  assign raw   = {btn_clr, btn_dec, btn_inc};
  assign press = db_q & ~db_prev_q;

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      dc_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dc_q[i] == DcLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          dc_d[i] = dc_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) dc_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 3; i++) dc_q[i] <= dc_d[i];
    end
  end

  // Repeat FSMs for inc and dec; a released button drops straight back to idle.
  always_comb begin
    req = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = '0;
      if (!db_q[i]) begin
        state_d[i] = StIdle;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (press[i]) begin
              req[i] = 1'b1;
              if (REPEAT_EN) state_d[i] = StDelay;
            end
          end
          StDelay: begin
            if (timer_q[i] == DelayLast) begin
              req[i]     = 1'b1;
              state_d[i] = StRepeat;
            end else begin
              timer_d[i] = timer_q[i] + 1'b1;
            end
          end
          StRepeat: begin
            if (timer_q[i] == RateLast) begin
              req[i] = 1'b1;
            end else begin
              timer_d[i] = timer_q[i] + 1'b1;
            end
          end
          default: state_d[i] = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StIdle;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // clr wins; simultaneous inc and dec cancel out.
  always_comb begin
    count_d = count_q;
    if (press[2]) begin
      count_d = '0;
    end else if (req[0] && !req[1]) begin
      if (count_q == MaxVal) count_d = SATURATE ? MaxVal : '0;
      else                   count_d = count_q + 1'b1;
    end else if (req[1] && !req[0]) begin
      if (count_q == '0) count_d = SATURATE ? '0 : MaxVal;
      else               count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      step_q   <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      step_q   <= (count_d != count_q);
      at_max_q <= (count_d == MaxVal);
      at_min_q <= (count_d == '0);
    end
  end

  assign count  = count_q;
  assign step   = step_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;

endmodule
